// File: rtl/cardinal_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cardinal_pkg                                                      |
// | Shared constants for the ring CMP: NIC register map, widths, VC.  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package cardinal_pkg;

    localparam int DATA_W = 64;

    localparam logic [1:0] NIC_IN_DATA  = 2'b00;
    localparam logic [1:0] NIC_IN_STAT  = 2'b01;
    localparam logic [1:0] NIC_OUT_DATA = 2'b10;
    localparam logic [1:0] NIC_OUT_STAT = 2'b11;

    // Packet bit 0 (the MSB in big-endian numbering) carries the virtual channel.
    localparam int VC_BIT = 0;

endpackage
`default_nettype wire

// File: rtl/nic_buf.sv
`default_nettype none
// +------------------------------------------------------------------+
// | nic_buf                                                           |
// | One-entry packet buffer with write/read pulses and a full flag.   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module nic_buf
    import cardinal_pkg::*;
#(
    parameter int DATA_W_P = DATA_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              wr,
    input  logic [0:DATA_W_P-1] wr_data,
    input  logic              rd,
    output logic              full,
    output logic [0:DATA_W_P-1] data
);

    logic                full_q, full_d;
    logic [0:DATA_W_P-1] data_q, data_d;

    // A write is only honoured into an empty slot; a read empties a full slot.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (wr && !full_q) begin
            full_d = 1'b1;
            data_d = wr_data;
        end else if (rd && full_q) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full = full_q;
    assign data = data_q;

endmodule
`default_nettype wire

// File: rtl/ring_nic.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ring_nic                                                          |
// | Processor-to-ring NIC: 4-word register window, one-entry in/out   |
// | buffers. Optional NIC_DROP_CNT_EN enables the dropped-write count.|
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module ring_nic
    import cardinal_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int ADDR_W   = 2
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [0:DATA_W_P-1] d_in,
    output logic [0:DATA_W_P-1] d_out,
    input  logic                nicEn,
    input  logic                nicWrEn,
    input  logic                net_si,
    output logic                net_ri,
    input  logic [0:DATA_W_P-1] net_di,
    output logic                net_so,
    input  logic                net_ro,
    output logic [0:DATA_W_P-1] net_do,
    input  logic                net_polarity,
    output logic [7:0]          drop_cnt
);

    logic                cpu_rd, cpu_wr;
    logic                in_wr, in_rd, in_full;
    logic                out_wr, out_full;
    logic [0:DATA_W_P-1] in_data, out_data;

    assign cpu_rd = nicEn && !nicWrEn;
    assign cpu_wr = nicEn && nicWrEn;

    assign net_ri = !in_full;
    assign in_wr  = net_si && !in_full;
    assign in_rd  = cpu_rd && (addr == NIC_IN_DATA) && in_full;

    // Write is judged on pre-edge out_full, so a write racing a send is dropped.
    assign out_wr = cpu_wr && (addr == NIC_OUT_DATA) && !out_full;
    assign net_so = out_full && net_ro && (out_data[VC_BIT] == net_polarity);
    assign net_do = out_data;

    nic_buf #(.DATA_W_P(DATA_W_P)) u_in_buf (
        .CLK     (CLK),
        .RESET   (RESET),
        .wr      (in_wr),
        .wr_data (net_di),
        .rd      (in_rd),
        .full    (in_full),
        .data    (in_data)
    );

    nic_buf #(.DATA_W_P(DATA_W_P)) u_out_buf (
        .CLK     (CLK),
        .RESET   (RESET),
        .wr      (out_wr),
        .wr_data (d_in),
        .rd      (net_so),
        .full    (out_full),
        .data    (out_data)
    );

    always_comb begin
        d_out = '0;
        if (cpu_rd) begin
            case (addr)
                NIC_IN_DATA:  d_out = in_data;
                NIC_IN_STAT:  d_out[DATA_W_P-1] = in_full;
                NIC_OUT_DATA: d_out = out_data;
                default:      d_out[DATA_W_P-1] = out_full;
            endcase
        end
    end

`ifdef NIC_DROP_CNT_EN
    logic       out_drop;
    logic [7:0] drop_cnt_q, drop_cnt_d;

    assign out_drop = cpu_wr && (addr == NIC_OUT_DATA) && out_full;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (out_drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            drop_cnt_q <= 8'h00;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 8'h00;
`endif

endmodule
`default_nettype wire

// File: doc/ring_nic.md
# ring_nic

Network interface controller joining one node's processor to its ring router in the four-node CMP. Exposes a 4-word register window on the processor's NIC port: input-channel data/status and output-channel data/status. Each channel has a one-entry 64-bit buffer, filled and drained by two independent handshakes. The processor polls the status words; the router side uses send/ready handshakes gated by the ring's virtual-channel polarity.

## Interface
Parameters:
- DATA_W, 64, packet and register width (bit 0 is MSB, big-endian [0:DATA_W-1])
- ADDR_W, 2, processor register-window address width

Ports:
- CLK  input  1  system clock
- RESET  input  1  synchronous, active-high reset
- addr  input  2  register select: 00 in-data, 01 in-status, 10 out-data, 11 out-status
- d_in  input  64  processor write data
- d_out  output  64  processor read data
- nicEn  input  1  access enable
- nicWrEn  input  1  1 = write, 0 = read (valid only with nicEn)
- net_si  input  1  router has a packet for this node
- net_ri  output  1  NIC can accept an inbound packet
- net_di  input  64  inbound packet
- net_so  output  1  NIC is sending an outbound packet
- net_ro  input  1  router can accept an outbound packet
- net_do  output  64  outbound packet
- net_polarity  input  1  current ring VC phase (toggles every cycle)
- drop_cnt  output  8  dropped-write counter (see Configuration)

## Operation
- State: in_buf[0:63], in_full; out_buf[0:63], out_full.
- Inbound: net_ri = ~in_full. At a CLK edge with net_si && net_ri: in_buf <= net_di, in_full <= 1.
- Processor read addr 00: d_out = in_buf. At that edge, in_full <= 0. Reading while empty returns stale in_buf, no state change.
- Read addr 01: d_out = {63'b0, in_full}. Read addr 11: d_out = {63'b0, out_full}. Read addr 10: d_out = out_buf. Status reads have no side effect.
- d_out = 0 when nicEn = 0 or nicWrEn = 1.
- Write addr 10 while out_full = 0: out_buf <= d_in, out_full <= 1. Write while out_full = 1: dropped, out_buf unchanged. Writes to 00/01/11 are ignored.
- Outbound: net_so = out_full && net_ro && (out_buf[0] == net_polarity). Bit 0 is the packet's VC. net_do = out_buf always. At an edge with net_so = 1: out_full <= 0.
- A CPU write and a send in the same cycle: the write is judged on the pre-edge out_full, so it is dropped, and the buffer empties.
- A CPU read of 00 while in_full = 1: net_ri stays 0 that cycle. The next inbound packet can be accepted no earlier than the following cycle.

## Timing
- Reset values: in_full = 0, out_full = 0, in_buf = 0, out_buf = 0, drop_cnt = 0. Therefore net_ri = 1, net_so = 0, d_out = 0, net_do = 0.
- RESET mid-transfer discards both buffers, including an unsent packet. A packet offered on net_si during RESET is not captured.
- d_out, net_ri and net_so are combinational from registers and current inputs. No pipeline latency.
- Inbound packet is visible on in-status at the cycle after the capture edge.
- Outbound send occurs at the first cycle where net_ro = 1 and the polarity matches. Worst case is 2 cycles after out_full is set, if the router is ready.
- Throughput: at most one packet per 2 cycles per direction at the processor (fill and drain use separate edges).

## Configuration
- NIC_DROP_CNT_EN defined: drop_cnt is an 8-bit counter, incremented on every dropped write to addr 10, saturating at 8'hFF and cleared by RESET.
- NIC_DROP_CNT_EN undefined: drop_cnt tied to 8'h00 and no counter logic is generated.
- The port list is identical in both cases.

## Structure
- Shared package (cardinal_pkg): NIC address constants (NIC_IN_DATA = 2'b00, NIC_IN_STAT = 2'b01, NIC_OUT_DATA = 2'b10, NIC_OUT_STAT = 2'b11), DATA_W, and the VC bit index (VC_BIT = 0).
- One sub-module, nic_buf: a one-entry buffer with a wr/rd pulse interface and a full flag. It is instantiated twice, once for inbound and once for outbound.

## Test plan
- Reset, then idle → net_ri = 1, net_so = 0, read 01 gives 64'h0, read 11 gives 64'h0.
- net_si = 1 with net_di = 64'h0123_4567_89AB_CDEF for one cycle → net_ri = 0 next cycle. Read 01 gives 64'h1. Read 00 gives 64'h0123_4567_89AB_CDEF, and net_ri = 1 the cycle after.
- Write addr 10 with 64'h8000_0000_0000_00AA, net_ro = 1, polarity toggling → net_so asserts only in a cycle with polarity = 1, exactly once, and net_do = the written value. Read 11 gives 0 afterwards.
- net_ro = 0, then two writes to addr 10 (64'h1, then 64'h2) → out_buf = 64'h1. With NIC_DROP_CNT_EN, drop_cnt = 1; without it, drop_cnt = 0.
- A CPU write to addr 10 in the same cycle as a send edge → the write is dropped and out_full = 0 after the edge.
- RESET asserted while out_full = 1 and in_full = 1 → both flags are 0 the next cycle, and no net_so pulse occurs.
